// File: rtl/mips_pipe_pkg.sv
// Shared MIPS pipeline definitions: bypass select codes, register-zero index,
// forwarding/stall FSM states and the bypass priority helper.
package mips_pipe_pkg;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;
  localparam logic [1:0] FWD_WB    = 2'b11;

  localparam int REG_ZERO = 0;

  typedef enum logic {
    IDLE  = 1'b0,
    STALL = 1'b1
  } fwd_stall_state_t;

  // Youngest producer wins: EX result, then MEM/WB latch, then WB write data.
  function automatic logic [1:0] fwd_pick(input logic ex_hit,
                                          input logic mem_hit,
                                          input logic wb_hit);
    logic [1:0] sel;
    sel = FWD_RF;
    if (ex_hit)
      sel = FWD_EXMEM;
    else if (mem_hit)
      sel = FWD_MEMWB;
    else if (wb_hit)
      sel = FWD_WB;
    return sel;
  endfunction

endpackage

// File: rtl/fwd_stall_ctrl_if.sv
// Pipeline-side signal bundle for the forwarding / load-use stall controller.
interface fwd_stall_ctrl_if #(
  parameter int NUM_RD = 2,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
);

  logic                     flush;
  logic                     id_valid;
  logic [NUM_RD*REG_AW-1:0] id_src;
  logic [NUM_RD-1:0]        id_src_used;
  logic [REG_AW-1:0]        ex_wreg;
  logic                     ex_regwrite;
  logic                     ex_memread;
  logic [REG_AW-1:0]        mem_wreg;
  logic                     mem_regwrite;
  logic [REG_AW-1:0]        wb_wreg;
  logic                     wb_regwrite;
  logic [NUM_RD*2-1:0]      fwd_sel;
  logic                     stall;
  logic [CNT_W-1:0]         stall_cnt;

  modport master (
    output flush, id_valid, id_src, id_src_used,
    output ex_wreg, ex_regwrite, ex_memread,
    output mem_wreg, mem_regwrite, wb_wreg, wb_regwrite,
    input  fwd_sel, stall, stall_cnt
  );

  modport slave (
    input  flush, id_valid, id_src, id_src_used,
    input  ex_wreg, ex_regwrite, ex_memread,
    input  mem_wreg, mem_regwrite, wb_wreg, wb_regwrite,
    output fwd_sel, stall, stall_cnt
  );

endinterface

// File: rtl/fwd_match.sv
// Per-port ID source comparator: picks the bypass select for one source
// register and flags a load-use collision with the EX-stage load.
module fwd_match
  import mips_pipe_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic              id_valid,
  input  logic [REG_AW-1:0] src,
  input  logic              used,
  input  logic [REG_AW-1:0] ex_wreg,
  input  logic              ex_regwrite,
  input  logic              ex_memread,
  input  logic [REG_AW-1:0] mem_wreg,
  input  logic              mem_regwrite,
  input  logic [REG_AW-1:0] wb_wreg,
  input  logic              wb_regwrite,
  output logic [1:0]        sel,
  output logic              load_hit
);

  logic live;
  logic ex_match;
  logic mem_match;
  logic wb_match;

  // $0 is hard-wired, so neither a zero source nor a zero destination may bypass.
  assign live      = id_valid & used & (src != REG_AW'(REG_ZERO));
  assign ex_match  = live & ex_regwrite  & (ex_wreg  == src) & (ex_wreg  != REG_AW'(REG_ZERO));
  assign mem_match = live & mem_regwrite & (mem_wreg == src) & (mem_wreg != REG_AW'(REG_ZERO));
  assign wb_match  = live & wb_regwrite  & (wb_wreg  == src) & (wb_wreg  != REG_AW'(REG_ZERO));

  assign sel      = fwd_pick(ex_match & ~ex_memread, mem_match, wb_match);
  assign load_hit = ex_match & ex_memread;

endmodule

// File: rtl/fwd_stall_ctrl.sv
// Forwarding and load-use hazard controller: registered EX bypass selects,
// LOAD_LAT-cycle stall FSM and a saturating stall-cycle counter.
module fwd_stall_ctrl
  import mips_pipe_pkg::*;
#(
  parameter int NUM_RD   = 2,
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 32
) (
  input logic            clk,
  input logic            rst,
  fwd_stall_ctrl_if.slave bus
);

  localparam logic [2:0] LAT_M1 = 3'(LOAD_LAT - 1);

  logic [NUM_RD*2-1:0] sel_comb;
  logic [NUM_RD-1:0]   hit_vec;
  logic                hit;

  fwd_stall_state_t state_reg, state_next;
  logic [2:0]       cnt_reg, cnt_next;
  logic             stall_next;

  logic [NUM_RD*2-1:0] fwd_sel_reg;
  logic [CNT_W-1:0]    stall_cnt_reg;

  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_port
    fwd_match #(
      .REG_AW(REG_AW)
    ) u_match (
      .id_valid    (bus.id_valid),
      .src         (bus.id_src[gi*REG_AW +: REG_AW]),
      .used        (bus.id_src_used[gi]),
      .ex_wreg     (bus.ex_wreg),
      .ex_regwrite (bus.ex_regwrite),
      .ex_memread  (bus.ex_memread),
      .mem_wreg    (bus.mem_wreg),
      .mem_regwrite(bus.mem_regwrite),
      .wb_wreg     (bus.wb_wreg),
      .wb_regwrite (bus.wb_regwrite),
      .sel         (sel_comb[gi*2 +: 2]),
      .load_hit    (hit_vec[gi])
    );
  end

  assign hit = |hit_vec;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= 3'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Flush overrides both a fresh hit and an in-progress stall.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    stall_next = 1'b0;
    if (bus.flush) begin
      state_next = IDLE;
      cnt_next   = 3'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (hit) begin
            stall_next = 1'b1;
            if (LOAD_LAT > 1) begin
              state_next = STALL;
              cnt_next   = LAT_M1;
            end
          end
        end
        STALL: begin
          stall_next = 1'b1;
          cnt_next   = cnt_reg - 3'd1;
          if (cnt_reg == 3'd1)
            state_next = IDLE;
        end
        default: begin
          state_next = IDLE;
          cnt_next   = 3'd0;
        end
      endcase
    end
  end

  // A stalled or flushed ID slot becomes a bubble in EX, so it must not bypass.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      fwd_sel_reg <= '0;
    else if (bus.flush || stall_next)
      fwd_sel_reg <= '0;
    else
      fwd_sel_reg <= sel_comb;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_cnt_reg <= '0;
    else if (stall_next && (stall_cnt_reg != {CNT_W{1'b1}}))
      stall_cnt_reg <= stall_cnt_reg + 1'b1;
  end

  assign bus.fwd_sel   = fwd_sel_reg;
  assign bus.stall     = stall_next;
  assign bus.stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_fwd_stall_ctrl.sv
// Bench for fwd_stall_ctrl: two instances (LOAD_LAT=3/CNT_W=4, LOAD_LAT=1/CNT_W=32)
// share stimulus and are checked every cycle against a remaining-stall-cycles model.
module tb_fwd_stall_ctrl;
  import mips_pipe_pkg::*;

  localparam int NUM_RD = 2;
  localparam int REG_AW = 5;

  logic clk = 1'b0;
  logic rst;
  logic                     flush;
  logic                     id_valid;
  logic [NUM_RD*REG_AW-1:0] id_src;
  logic [NUM_RD-1:0]        id_src_used;
  logic [REG_AW-1:0]        ex_wreg, mem_wreg, wb_wreg;
  logic                     ex_regwrite, ex_memread, mem_regwrite, wb_regwrite;

  int compared   = 0;
  int mismatched = 0;

  fwd_stall_ctrl_if #(.NUM_RD(NUM_RD), .REG_AW(REG_AW), .CNT_W(4))  ifa ();
  fwd_stall_ctrl_if #(.NUM_RD(NUM_RD), .REG_AW(REG_AW), .CNT_W(32)) ifb ();

  assign ifa.flush = flush;        assign ifb.flush = flush;
  assign ifa.id_valid = id_valid;  assign ifb.id_valid = id_valid;
  assign ifa.id_src = id_src;      assign ifb.id_src = id_src;
  assign ifa.id_src_used = id_src_used;   assign ifb.id_src_used = id_src_used;
  assign ifa.ex_wreg = ex_wreg;           assign ifb.ex_wreg = ex_wreg;
  assign ifa.ex_regwrite = ex_regwrite;   assign ifb.ex_regwrite = ex_regwrite;
  assign ifa.ex_memread = ex_memread;     assign ifb.ex_memread = ex_memread;
  assign ifa.mem_wreg = mem_wreg;         assign ifb.mem_wreg = mem_wreg;
  assign ifa.mem_regwrite = mem_regwrite; assign ifb.mem_regwrite = mem_regwrite;
  assign ifa.wb_wreg = wb_wreg;           assign ifb.wb_wreg = wb_wreg;
  assign ifa.wb_regwrite = wb_regwrite;   assign ifb.wb_regwrite = wb_regwrite;

  fwd_stall_ctrl #(.NUM_RD(NUM_RD), .REG_AW(REG_AW), .LOAD_LAT(3), .CNT_W(4)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa)
  );
  fwd_stall_ctrl #(.NUM_RD(NUM_RD), .REG_AW(REG_AW), .LOAD_LAT(1), .CNT_W(32)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb)
  );

  logic [3:0]  fwd_o [2];
  logic        stall_o [2];
  logic [31:0] cnt_o [2];
  assign fwd_o[0] = ifa.fwd_sel;  assign fwd_o[1] = ifb.fwd_sel;
  assign stall_o[0] = ifa.stall;  assign stall_o[1] = ifb.stall;
  assign cnt_o[0] = 32'(ifa.stall_cnt);
  assign cnt_o[1] = ifb.stall_cnt;

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int     lat [2]  = '{3, 1};
  longint cmax [2] = '{64'd15, 64'hFFFF_FFFF};
  int     rem [2],  nrem [2];
  logic [3:0] mfwd [2], nfwd [2];
  longint mcnt [2], ncnt [2];

  function automatic int port_sel(input int p);
    int s;
    s = int'(id_src[p*REG_AW +: REG_AW]);
    if (!id_valid || !id_src_used[p] || s == 0) return 0;
    if (ex_regwrite && !ex_memread && int'(ex_wreg) == s) return 1;
    if (mem_regwrite && int'(mem_wreg) == s) return 2;
    if (wb_regwrite && int'(wb_wreg) == s) return 3;
    return 0;
  endfunction

  function automatic bit port_hit(input int p);
    int s;
    s = int'(id_src[p*REG_AW +: REG_AW]);
    return id_valid && id_src_used[p] && s != 0 && ex_regwrite && ex_memread
           && int'(ex_wreg) == s;
  endfunction

  always @(negedge clk) begin
    logic [3:0] sel_all;
    bit hit;
    bit es;
    string tag;
    sel_all = '0;
    hit = 1'b0;
    for (int p = 0; p < NUM_RD; p++) begin
      sel_all[p*2 +: 2] = 2'(port_sel(p));
      hit = hit | port_hit(p);
    end
    for (int d = 0; d < 2; d++) begin
      tag = (d == 0) ? "A" : "B";
      es = !flush && (rem[d] > 0 || hit);
      if (!rst) begin
        check({tag, ".stall"},     64'(stall_o[d]), 64'(es));
        check({tag, ".fwd_sel"},   64'(fwd_o[d]),   64'(mfwd[d]));
        check({tag, ".stall_cnt"}, 64'(cnt_o[d]),   64'(mcnt[d]));
      end
      nrem[d] = flush ? 0 : (rem[d] > 0 ? rem[d] - 1 : (hit ? lat[d] - 1 : 0));
      nfwd[d] = (flush || es) ? 4'd0 : sel_all;
      ncnt[d] = (es && mcnt[d] < cmax[d]) ? mcnt[d] + 1 : mcnt[d];
    end
  end

  always @(posedge clk or posedge rst) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        rem[d]  <= 0;
        mfwd[d] <= 4'd0;
        mcnt[d] <= 0;
      end else begin
        rem[d]  <= nrem[d];
        mfwd[d] <= nfwd[d];
        mcnt[d] <= ncnt[d];
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    flush = 0; id_valid = 0; id_src = '0; id_src_used = '0;
    ex_wreg = '0; ex_regwrite = 0; ex_memread = 0;
    mem_wreg = '0; mem_regwrite = 0; wb_wreg = '0; wb_regwrite = 0;
  endtask

  task automatic load_use_on_rt(input logic [4:0] r);
    id_valid = 1; id_src = {r, 5'd0}; id_src_used = 2'b10;
    ex_wreg = r; ex_regwrite = 1; ex_memread = 1;
  endtask

  function automatic logic [4:0] rnd_reg();
    return ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 3));
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    clear_inputs();
    #22 rst = 1'b0;
    cyc();
    check("reset.stall_a", 64'(stall_o[0]), 64'd0);
    check("reset.fwd_a",   64'(fwd_o[0]),   64'd0);
    check("reset.cnt_b",   64'(cnt_o[1]),   64'd0);

    // 1: EX add writes $8, rs=$8; EX also beats MEM on the same register
    id_valid = 1; id_src = {5'd0, 5'd8}; id_src_used = 2'b01;
    ex_wreg = 5'd8; ex_regwrite = 1; mem_wreg = 5'd8; mem_regwrite = 1;
    #1 check("t1.stall_a", 64'(stall_o[0]), 64'd0);
    cyc();
    check("t1.fwd_a", 64'(fwd_o[0]), 64'h1);
    check("t1.fwd_b", 64'(fwd_o[1]), 64'h1);
    $display("test 1: EX bypass fwd_sel=%b", fwd_o[0]);

    // 2: MEM and WB both write $9, rt=$9; then WB alone
    clear_inputs();
    id_valid = 1; id_src = {5'd9, 5'd0}; id_src_used = 2'b10;
    mem_wreg = 5'd9; mem_regwrite = 1; wb_wreg = 5'd9; wb_regwrite = 1;
    cyc();
    check("t2.fwd_mem", 64'(fwd_o[0]), 64'h8);
    mem_regwrite = 0;
    cyc();
    check("t2.fwd_wb", 64'(fwd_o[0]), 64'hC);
    $display("test 2: MEM over WB fwd_sel=%b", fwd_o[0]);

    // 3: writes to $0 never bypass or stall
    clear_inputs();
    id_valid = 1; id_src = '0; id_src_used = 2'b11;
    ex_wreg = 5'd0; ex_regwrite = 1; ex_memread = 1; mem_regwrite = 1;
    #1 check("t3.stall_a", 64'(stall_o[0]), 64'd0);
    cyc();
    check("t3.fwd_a", 64'(fwd_o[0]), 64'd0);
    $display("test 3: $0 ignored fwd_sel=%b", fwd_o[0]);

    // 4: load-use on $4; A stalls 3 cycles, B stalls 1
    clear_inputs();
    cyc();
    load_use_on_rt(5'd4);
    #1 check("t4.stall_a0", 64'(stall_o[0]), 64'd1);
    check("t4.stall_b0", 64'(stall_o[1]), 64'd1);
    cyc();
    ex_regwrite = 0; ex_memread = 0;
    #1 check("t4.stall_a1", 64'(stall_o[0]), 64'd1);
    check("t4.stall_b1", 64'(stall_o[1]), 64'd0);
    check("t4.fwd_a1",   64'(fwd_o[0]),   64'd0);
    cyc();
    check("t4.stall_a2", 64'(stall_o[0]), 64'd1);
    cyc();
    check("t4.stall_a3", 64'(stall_o[0]), 64'd0);
    check("t4.cnt_a",    64'(cnt_o[0]),   64'd3);
    check("t4.cnt_b",    64'(cnt_o[1]),   64'd1);
    check("t4.fwd_a3",   64'(fwd_o[0]),   64'd0);
    $display("test 4: load-use stall_cnt A=%0d B=%0d", cnt_o[0], cnt_o[1]);

    // 5: flush beats a load-use hit and a MEM bypass on rs
    clear_inputs();
    load_use_on_rt(5'd4);
    id_src = {5'd4, 5'd7}; id_src_used = 2'b11; mem_wreg = 5'd7; mem_regwrite = 1;
    flush = 1;
    #1 check("t5.stall_a", 64'(stall_o[0]), 64'd0);
    check("t5.stall_b", 64'(stall_o[1]), 64'd0);
    cyc();
    clear_inputs();
    #1 check("t5.stall_after", 64'(stall_o[0]), 64'd0);
    check("t5.fwd_a", 64'(fwd_o[0]), 64'd0);
    check("t5.cnt_a", 64'(cnt_o[0]), 64'd3);
    $display("test 5: flush wins stall=%b", stall_o[0]);

    // 6: 20 back-to-back stall cycles saturate A at 15, then reset mid-STALL
    load_use_on_rt(5'd4);
    for (int i = 0; i < 20; i++) cyc();
    check("t6.cnt_a_sat", 64'(cnt_o[0]), 64'd15);
    check("t6.cnt_b",     64'(cnt_o[1]), 64'd21);
    clear_inputs();
    cyc();
    load_use_on_rt(5'd4);
    cyc();
    clear_inputs();
    #1 check("t6.in_stall", 64'(stall_o[0]), 64'd1);
    rst = 1'b1;
    #1 check("t6.rst_stall", 64'(stall_o[0]), 64'd0);
    check("t6.rst_cnt_a", 64'(cnt_o[0]), 64'd0);
    check("t6.rst_cnt_b", 64'(cnt_o[1]), 64'd0);
    #4 rst = 1'b0;
    cyc();
    check("t6.post_rst", 64'(stall_o[0]), 64'd0);
    $display("test 6: saturation and async reset done");

    // random phase
    for (int n = 0; n < 3000; n++) begin
      cyc();
      flush        = ($urandom_range(0, 15) == 0);
      id_valid     = ($urandom_range(0, 7) != 0);
      id_src       = {rnd_reg(), rnd_reg()};
      id_src_used  = 2'($urandom_range(0, 3));
      ex_wreg      = rnd_reg();
      ex_regwrite  = ($urandom_range(0, 3) != 0);
      ex_memread   = ($urandom_range(0, 2) == 0);
      mem_wreg     = rnd_reg();
      mem_regwrite = ($urandom_range(0, 1) == 1);
      wb_wreg      = rnd_reg();
      wb_regwrite  = ($urandom_range(0, 1) == 1);
    end
    cyc();
    clear_inputs();
    cyc();
    cyc();
    $display("random: 3000 cycles, stall_cnt A=%0d B=%0d", cnt_o[0], cnt_o[1]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
